// File: rtl/mult_shift_add_ctrl.sv
// mult_shift_add_ctrl: shift-add multiplier FSM and accumulator with Load/K counter handshake.
// Optional K cross-check with sticky Err output when MULT_KCHECK_EN is defined.
module mult_shift_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  input  logic               K,
  output logic               Load,
  output logic               Busy,
  output logic               Done,
`ifdef MULT_KCHECK_EN
  output logic               Err,
`endif
  output logic [2*WIDTH-1:0] Product
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc, acc_nxt;
  logic [WIDTH:0] sum;
  logic last, bad;
  assign Load = state == IDLE && Start;
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  // acc[2W] is always 0 here, so folding it in leaves the add a plain W+1-bit sum
  assign sum = {acc[2*WIDTH], acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & mcand};
  assign acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
`ifdef MULT_KCHECK_EN
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [CW-1:0] iter;
  assign bad = K != (iter == CW'(WIDTH - 1));
  assign last = K | bad;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      iter <= '0;
      Err  <= 1'b0;
    end else if (Load) begin
      iter <= '0;
      Err  <= 1'b0;
    end else if (state == RUN) begin
      iter <= iter + 1'b1;
      if (bad) Err <= 1'b1;
    end
  end
`else
  assign bad = 1'b0;
  assign last = K;
`endif
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      Product <= '0;
    end else if (state == IDLE) begin
      if (Start) begin
        state <= RUN;
        mcand <= Multiplicand;
        acc   <= {{(WIDTH + 1){1'b0}}, Multiplier};
      end
    end else if (state == RUN) begin
      acc <= acc_nxt;
      if (last) begin
        state   <= DONE;
        Product <= bad ? '0 : acc_nxt[2*WIDTH-1:0];
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// tb_mult_shift_add_ctrl: self-checking bench for mult_shift_add_ctrl (WIDTH=16) with a behavioural
// iteration counter; reference products come from plain integer multiplication.
module tb_mult_shift_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, kforce = 1'b0;
  logic k, load, busy, done;
  logic [15:0] mcand = '0, mplier = '0;
  logic [31:0] product;
  logic [4:0] cnt;
  int errors = 0, checks = 0;
`ifdef MULT_KCHECK_EN
  logic err;
`endif
  always #5 clk = ~clk;
  // Counter: cleared by Load, raises K at terminal count 15 (or 5 when forcing a bad K)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= load ? 5'd0 : (cnt == 5'd31 ? cnt : cnt + 5'd1);
  end
  assign k = kforce ? cnt == 5'd5 : cnt == 5'd15;

  mult_shift_add_ctrl #(.WIDTH(16)) dut (
    .Clk(clk),
    .Rst_n(rst_n),
    .Start(start),
    .Multiplicand(mcand),
    .Multiplier(mplier),
    .K(k),
    .Load(load),
    .Busy(busy),
    .Done(done),
`ifdef MULT_KCHECK_EN
    .Err(err),
`endif
    .Product(product)
  );

  // One operation from a negedge: returns edges to Done, busy cycles, load cycles, product changes before Done
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, output int lat, output int nbusy,
                       output int nload, output int nchg, output logic [31:0] p);
    logic [31:0] p0;
    lat = -1; nbusy = 0; nload = 0; nchg = 0; p = 'x;
    p0 = product;
    start = 1'b1; mcand = x; mplier = y;
    #1 nload += int'(load);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      nbusy += int'(busy);
      nload += int'(load);
      if (done) begin
        lat = i - 1;
        p = product;
      end else if (product !== p0) nchg++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", load); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product: got %h want 0", product); end
`ifdef MULT_KCHECK_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, nb, nl, nc;
    logic [31:0] p;
    do_op(16'd3, 16'd5, lat, nb, nl, nc, p);
    checks++; if (p !== 32'h0000000F) begin errors++; $display("FAIL basic_product: got %h want 0000000f", p); end
    checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d want 16", lat); end
    checks++; if (nb !== 17) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 17", nb); end
    checks++; if (nl !== 1) begin errors++; $display("FAIL basic_load_cycles: got %0d want 1", nl); end
    checks++; if (nc !== 0) begin errors++; $display("FAIL basic_product_stable: got %0d changes want 0", nc); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_after_done: got busy,done=%b want 00", {busy, done}); end
    checks++; if (product !== 32'h0000000F) begin errors++; $display("FAIL basic_hold: got %h want 0000000f", product); end
  endtask

  task automatic test_ignore_start;
    int nd = 0, nl = 0;
    logic [31:0] p = 'x;
    mcand = 16'd3; mplier = 16'd5; start = 1'b1;
    #1 nl += int'(load);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 8) begin
        start = 1'b1; mcand = 16'd9; mplier = 16'd9;
        #1;
      end
      nl += int'(load);
      if (done) begin
        nd++;
        p = product;
      end
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    checks++; if (nl !== 1) begin errors++; $display("FAIL ignore_load_count: got %0d want 1", nl); end
    checks++; if (p !== 32'h0000000F) begin errors++; $display("FAIL ignore_product: got %h want 0000000f", p); end
  endtask

  task automatic test_reset_mid_run;
    int lat, nb, nl, nc;
    logic [31:0] p;
    mcand = 16'd100; mplier = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL midrst_product: got %h want 0", product); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++; if ({busy, load} !== 2'b00) begin errors++; $display("FAIL midrst_idle: got busy,load=%b want 00", {busy, load}); end
    end
    do_op(16'd100, 16'd200, lat, nb, nl, nc, p);
    checks++; if (p !== 32'h00004E20) begin errors++; $display("FAIL midrst_rerun_product: got %h want 00004e20", p); end
    checks++; if (lat !== 16) begin errors++; $display("FAIL midrst_rerun_latency: got %0d want 16", lat); end
  endtask

  task automatic test_boundary;
    int lat, nb, nl, nc;
    logic [31:0] p;
    do_op(16'hFFFF, 16'hFFFF, lat, nb, nl, nc, p);
    checks++; if (p !== 32'hFFFE0001) begin errors++; $display("FAIL max_product: got %h want fffe0001", p); end
    do_op(16'h0000, 16'h1234, lat, nb, nl, nc, p);
    checks++; if (p !== 32'h0) begin errors++; $display("FAIL zero_product: got %h want 0", p); end
    checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency: got %0d want 16", lat); end
    do_op(16'h8001, 16'h0000, lat, nb, nl, nc, p);
    checks++; if (p !== 32'h0) begin errors++; $display("FAIL zero_b_product: got %h want 0", p); end
  endtask

  task automatic test_random;
    int lat, nb, nl, nc;
    logic [31:0] p, exp_p;
    logic [15:0] x, y;
    for (int n = 0; n < 12; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      exp_p = 32'(x) * 32'(y);
      do_op(x, y, lat, nb, nl, nc, p);
      checks++; if (p !== exp_p) begin errors++; $display("FAIL random_product %h*%h: got %h want %h", x, y, p, exp_p); end
      checks++; if (lat !== 16 || nc !== 0) begin errors++; $display("FAIL random_timing %h*%h: got lat=%0d chg=%0d want 16,0", x, y, lat, nc); end
    end
  endtask

  task automatic test_back_to_back;
    int last_done = -1, last_load = -1, nd = 0;
    mcand = 16'd2; mplier = 16'd7; start = 1'b1;
    for (int i = 0; i < 54; i++) begin
      #1;
      if (load) begin
        if (last_done >= 0) begin
          checks++; if (i - last_done !== 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", i - last_done); end
        end
        last_load = i;
      end
      if (done) begin
        nd++;
        last_done = i;
        checks++; if (product !== 32'h0000000E) begin errors++; $display("FAIL b2b_product: got %h want 0000000e", product); end
        checks++; if (i - last_load !== 17) begin errors++; $display("FAIL b2b_spacing: got %0d want 17", i - last_load); end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
    for (int i = 0; i < 25 && busy; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
  endtask

`ifdef MULT_KCHECK_EN
  task automatic test_kcheck;
    int lat, nb, nl, nc;
    logic [31:0] p;
    kforce = 1'b1;
    do_op(16'd3, 16'd5, lat, nb, nl, nc, p);
    kforce = 1'b0;
    checks++; if (lat !== 6) begin errors++; $display("FAIL kchk_latency: got %0d want 6", lat); end
    checks++; if (p !== 32'h0) begin errors++; $display("FAIL kchk_product: got %h want 0", p); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL kchk_err_sticky: got %b want 1", err); end
    do_op(16'd3, 16'd5, lat, nb, nl, nc, p);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL kchk_err_clear: got %b want 0", err); end
    checks++; if (p !== 32'h0000000F) begin errors++; $display("FAIL kchk_rerun_product: got %h want 0000000f", p); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid_run();
    test_boundary();
    test_random();
    test_back_to_back();
`ifdef MULT_KCHECK_EN
    test_kcheck();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
